// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch and load/store ports.
// One transaction at a time, fixed read latency, one-cycle acks, data has priority.
// Optional fetch starvation guard enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY    = 1,
  parameter int unsigned DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clk_en,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        arb_error,
  output logic [31:0] mem_a,
  output logic [31:0] mem_out_v,
  output logic [1:0]  mem_s,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_in_v
);

  localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LatW-1:0] LatInit = LatW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StWait, StAck} state_e;

  state_e          r_state;
  logic [LatW-1:0] r_lat;
  logic            r_is_data;
  logic [31:0]     r_i_rdata;
  logic [31:0]     r_d_rdata;
  logic            r_i_ack;
  logic            r_d_ack;
  logic            r_d_err;
  logic            r_arb_error;
  logic [31:0]     r_mem_a;
  logic [31:0]     r_mem_out_v;
  logic [1:0]      r_mem_s;
  logic            r_mem_read;
  logic            r_mem_write;

  logic w_d_bad;
  logic w_fair_fetch;
  logic w_grant_fetch;
  logic w_unused;

  // Misaligned halves/words and the reserved size code are rejected without touching memory.
  assign w_d_bad = (d_size == 2'b11) ||
                   ((d_size == 2'b01) && d_addr[0]) ||
                   ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned FairW = $clog2(DATA_BURST_MAX + 1);
  logic [FairW-1:0] r_fair_cnt;

  assign w_fair_fetch = i_req && (r_fair_cnt == FairW'(DATA_BURST_MAX));

  // Count data grants made while fetch waits; any fetch grant restarts the burst.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_fair_cnt <= '0;
    end else if (clk_en && (r_state == StIdle) && (i_req || d_req)) begin
      if (w_grant_fetch) begin
        r_fair_cnt <= '0;
      end else if (i_req) begin
        r_fair_cnt <= r_fair_cnt + FairW'(1);
      end
    end
  end
`else
  assign w_fair_fetch = 1'b0;
`endif

  assign w_grant_fetch = i_req && (!d_req || w_fair_fetch);
  assign w_unused      = ^i_addr[1:0] ^ (DATA_BURST_MAX != 0);

  // Transaction sequencer; every output is registered here.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= StIdle;
      r_lat       <= '0;
      r_is_data   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_arb_error <= 1'b0;
      r_mem_a     <= '0;
      r_mem_out_v <= '0;
      r_mem_s     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (clk_en) begin
      unique case (r_state)
        StIdle: begin
          if (w_grant_fetch) begin
            r_is_data   <= 1'b0;
            r_mem_a     <= {i_addr[31:2], 2'b00};
            r_mem_s     <= 2'b10;
            r_mem_out_v <= '0;
            r_mem_read  <= 1'b1;
            r_state     <= StCmd;
          end else if (d_req) begin
            r_is_data <= 1'b1;
            if (w_d_bad) begin
              r_d_ack     <= 1'b1;
              r_d_err     <= 1'b1;
              r_arb_error <= 1'b1;
              r_state     <= StAck;
            end else begin
              r_mem_a     <= d_addr;
              r_mem_s     <= d_size;
              r_mem_out_v <= d_we ? d_wdata : 32'h0;
              r_mem_read  <= !d_we;
              r_mem_write <= d_we;
              r_state     <= StCmd;
            end
          end
        end
        StCmd: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          if (r_mem_write) begin
            r_d_ack <= 1'b1;
            r_state <= StAck;
          end else begin
            r_lat   <= LatInit;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (r_lat == '0) begin
            if (r_is_data) begin
              r_d_rdata <= mem_in_v;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= mem_in_v;
              r_i_ack   <= 1'b1;
            end
            r_state <= StAck;
          end else begin
            r_lat <= r_lat - LatW'(1);
          end
        end
        StAck: begin
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
          r_d_err <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign i_rdata   = r_i_rdata;
  assign i_ack     = r_i_ack;
  assign d_rdata   = r_d_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign arb_error = r_arb_error;
  assign mem_a     = r_mem_a;
  assign mem_out_v = r_mem_out_v;
  assign mem_s     = r_mem_s;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with MEM_LATENCY=3, DATA_BURST_MAX=4.
// Expectation for the burst test follows MEM_ARB_FAIRNESS_EN.
module tb_mem_arbiter;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        nreset, clk_en;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata, mem_a, mem_out_v, mem_in_v;
  logic        i_ack, d_ack, d_err, arb_error, mem_read, mem_write;
  logic [1:0]  mem_s;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [32:0] pipe [L];
  bit          init_done;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(L), .DATA_BURST_MAX(4)) dut (
    .clk(clk), .nreset(nreset), .clk_en(clk_en),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .arb_error(arb_error),
    .mem_a(mem_a), .mem_out_v(mem_out_v), .mem_s(mem_s), .mem_read(mem_read),
    .mem_write(mem_write), .mem_in_v(mem_in_v)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Byte lanes follow the low address bits; store data is right-aligned.
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [1:0] sz,
                                        logic [1:0] lo);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[lo*8 +: 8] = wd[7:0];
      2'b01:   r[lo[1]*16 +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Memory model: read data valid exactly L enabled cycles after the command.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
      if (!init_done) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        init_done <= 1'b1;
      end
    end else if (clk_en) begin
      if (mem_write) mem[mem_a[9:2]] <= merge(mem[mem_a[9:2]], mem_out_v, mem_s, mem_a[1:0]);
      pipe[0] <= {mem_read, mem[mem_a[9:2]]};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_in_v = pipe[L-1][32] ? pipe[L-1][31:0] : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_a"}, mem_a, 32'h0);
    check({tag, "_rdata"}, i_rdata | d_rdata | mem_out_v, 32'h0);
    check({tag, "_ctl"}, 32'({i_ack, d_ack, d_err, arb_error, mem_read, mem_write, mem_s}), 32'h0);
  endtask

  // One isolated request; expectations derived from the access rules.
  task automatic do_txn(input string tag, input bit is_d, input bit we, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd);
    bit          bad, got, wrong;
    int          n, nrd, nwr, exp_lat;
    logic [31:0] seen_a, seen_v, rd;
    logic [1:0]  seen_s;
    logic        err;
    bad = is_d && ((sz == 2'b11) || ((sz == 2'b01) && addr[0]) ||
                   ((sz == 2'b10) && (addr[1:0] != 2'b00)));
    exp_lat = bad ? 1 : (is_d && we) ? 2 : L + 2;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    n = 0; nrd = 0; nwr = 0; got = 1'b0; wrong = 1'b0;
    seen_a = '0; seen_v = '0; seen_s = '0; rd = '0; err = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (mem_read || mem_write) begin
        seen_a = mem_a; seen_s = mem_s; seen_v = mem_out_v;
      end
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (is_d ? i_ack : d_ack) wrong = 1'b1;
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1; rd = is_d ? d_rdata : i_rdata; err = d_err;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_other_ack"}, 32'(wrong), 32'h0);
    check({tag, "_reads"}, 32'(nrd), 32'((!bad && !(is_d && we)) ? 1 : 0));
    check({tag, "_writes"}, 32'(nwr), 32'((!bad && is_d && we) ? 1 : 0));
    if (is_d) check({tag, "_err"}, 32'(err), 32'(bad));
    if (!bad) begin
      check({tag, "_mem_a"}, seen_a, is_d ? addr : {addr[31:2], 2'b00});
      check({tag, "_mem_s"}, 32'(seen_s), 32'(is_d ? sz : 2'b10));
    end
    if (!bad && is_d && we) begin
      check({tag, "_mem_out_v"}, seen_v, wd);
      ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wd, sz, addr[1:0]);
    end
    if (!bad && !(is_d && we)) check({tag, "_rdata"}, rd, ref_mem[addr[9:2]]);
    @(posedge clk);
  endtask

  initial begin
    int          n, dcnt, dn, in_n;
    bit          got_i, got_d;
    logic [31:0] fa, dv, ra, rw;
    logic [1:0]  rs;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    nreset = 1'b0; clk_en = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'b00; i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) nreset = 1'b1;

    // Reset while a fetch sits in WAIT: everything clears, no ack follows.
    @(negedge clk); i_req = 1'b1; i_addr = 32'h200;
    repeat (2) @(posedge clk);
    #2 nreset = 1'b0;
    #1 check_all_zero("reset_mid_read");
    i_req = 1'b0;
    @(negedge clk) nreset = 1'b1;
    n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      n += int'(i_ack | d_ack | mem_read | mem_write);
    end
    check("post_reset_quiet", 32'(n), 32'h0);
    do_txn("fetch_104", 1'b0, 1'b0, 2'b10, 32'h104, 32'h0);

    do_txn("store_40", 1'b1, 1'b1, 2'b10, 32'h40, 32'hDEAD_BEEF);
    do_txn("load_40", 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    check("load_40_value", d_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests: data first, fetch follows in a later IDLE.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h40; i_req = 1'b1; i_addr = 32'h7;
    n = 0; got_d = 1'b0; got_i = 1'b0; dn = 0; in_n = 0; fa = '0; dv = '0;
    while (!got_i && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (got_d && mem_read) fa = mem_a;
      if (d_ack) begin got_d = 1'b1; dn = n; dv = d_rdata; d_req = 1'b0; end
      if (i_ack) begin got_i = 1'b1; in_n = n; end
    end
    i_req = 1'b0;
    check("simul_data_ack", 32'(dn), 32'(L + 2));
    check("simul_fetch_ack", 32'(in_n), 32'(2 * L + 5));
    check("simul_fetch_addr", fa, 32'h4);
    check("simul_data_val", dv, ref_mem[32'h40 >> 2]);
    @(posedge clk);

    do_txn("half_21", 1'b1, 1'b0, 2'b01, 32'h21, 32'h0);
    check("arb_error_set", 32'(arb_error), 32'h1);
    do_txn("size_11", 1'b1, 1'b1, 2'b11, 32'h40, 32'h1234_5678);

    // Clock enable low for three cycles while the read command is up.
    @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h40;
    n = 0; dcnt = 0; got_d = 1'b0; dv = '0;
    while (!got_d && n < 40) begin
      @(posedge clk); #1;
      n++;
      dcnt += int'(mem_read);
      if (n == 1) clk_en = 1'b0;
      if (n == 4) clk_en = 1'b1;
      if (d_ack) begin got_d = 1'b1; dv = d_rdata; end
    end
    d_req = 1'b0;
    check("clken_read_cycles", 32'(dcnt), 32'h4);
    check("clken_ack_latency", 32'(n), 32'(L + 5));
    check("clken_data", dv, 32'hDEAD_BEEF);
    @(posedge clk);

    // Continuous stores with a fetch waiting.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h80; d_wdata = 32'h1357_9BDF;
    i_req = 1'b1; i_addr = 32'h300;
    ref_mem[32'h80 >> 2] = 32'h1357_9BDF;
    n = 0; dcnt = 0; got_i = 1'b0;
    while (!got_i && dcnt < 20 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (d_ack) dcnt++;
      if (i_ack) got_i = 1'b1;
    end
`ifdef MEM_ARB_FAIRNESS_EN
    check("fair_data_grants", 32'(dcnt), 32'h4);
    check("fair_fetch_granted", 32'(got_i), 32'h1);
`else
    check("strict_data_grants", 32'(dcnt), 32'd20);
    check("strict_fetch_starved", 32'(got_i), 32'h0);
`endif
    d_req = 1'b0;
    if (!got_i) begin
      n = 0;
      while (!got_i && n < 20) begin
        @(posedge clk); #1;
        n++;
        if (i_ack) got_i = 1'b1;
      end
    end
    check("burst_fetch_done", 32'(got_i), 32'h1);
    check("burst_fetch_data", i_rdata, ref_mem[32'h300 >> 2]);
    i_req = 1'b0;
    @(posedge clk);

    // Randomized isolated accesses against the reference memory.
    for (int k = 0; k < 24; k++) begin
      ra = 32'($urandom_range(0, 1023));
      rw = $urandom;
      rs = 2'($urandom_range(0, 3));
      do_txn($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rs, ra, rw);
    end

    check("arb_error_sticky", 32'(arb_error), 32'h1);
    @(negedge clk) nreset = 1'b0;
    #1 check_all_zero("final_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
